// File: rtl/pea_sequencer.sv
// rtl/pea_sequencer.sv - instruction sequencer: command pop, operand pops, core run, status token
// Optional build macro PEA_SEQ_FREE_SPACE_EN: firing also waits for output FIFO free space.
module pea_sequencer #(
    parameter int word_size       = 16,
    parameter int buffer_size_out = 32,
    localparam int FW             = $clog2(buffer_size_out)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [word_size-1:0] cmd_data,
    output logic                 cmd_rd_en,
    output logic                 data_rd_en,
    output logic [1:0]           next_mode_out,
    output logic [7:0]           mode,
    output logic [4:0]           arg2,
    input  logic [FW-1:0]        result_free_space,
    input  logic [FW-1:0]        status_free_space,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 status_wr_en,
    output logic [word_size-1:0] status_data,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_SETUP  = 3'd0,
        S_WAIT   = 3'd1,
        S_POP    = 3'd2,
        S_RUN    = 3'd3,
        S_STATUS = 3'd4
    } state_t;

    localparam logic [7:0] MODE_STP = 8'd0;
    localparam logic [7:0] MODE_EVP = 8'd1;
    localparam logic [7:0] MODE_EVB = 8'd2;
    localparam logic [7:0] MODE_RST = 8'd3;
    localparam int CW = (FW > 5) ? FW : 5;

    state_t               r_state;
    logic [7:0]           r_mode;
    logic [4:0]           r_arg2;
    logic [4:0]           r_count;
    logic                 r_data_rd_en;
    logic                 r_core_start;
    logic                 r_status_wr_en;
    logic [word_size-1:0] r_status_data;

    logic [4:0]           w_pop_count;
    logic                 w_fire;
    logic                 w_mode_valid;

    // Bits above the arg2 field carry nothing for this block.
    logic w_unused_cmd;
    assign w_unused_cmd = ^cmd_data[word_size-1:13];

    assign w_mode_valid = (r_mode <= MODE_RST);

    // Operand words each instruction consumes from the data FIFO.
    always_comb begin
        w_pop_count = 5'd0;
        case (r_mode)
            MODE_STP: w_pop_count = r_arg2;
            MODE_EVP: w_pop_count = 5'd1;
            MODE_EVB: w_pop_count = r_arg2;
            default:  w_pop_count = 5'd0;
        endcase
    end

`ifdef PEA_SEQ_FREE_SPACE_EN
    logic [4:0] w_res_need;
    // Fire only when the status token and the results it produces will fit downstream.
    always_comb begin
        w_res_need = (r_mode == MODE_EVB) ? r_arg2 : 5'd1;
        w_fire     = enable && (status_free_space != '0) &&
                     ((r_mode == MODE_RST) || (CW'(result_free_space) >= CW'(w_res_need)));
    end
`else
    logic w_unused_fs;
    assign w_unused_fs = ^{result_free_space, status_free_space};
    assign w_fire      = enable;
`endif

    // Sequencer state, latched instruction fields and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_SETUP;
            r_mode         <= 8'd0;
            r_arg2         <= 5'd0;
            r_count        <= 5'd0;
            r_data_rd_en   <= 1'b0;
            r_core_start   <= 1'b0;
            r_status_wr_en <= 1'b0;
            r_status_data  <= '0;
        end else begin
            case (r_state)
                S_SETUP: begin
                    if (enable) begin
                        r_mode  <= cmd_data[7:0];
                        r_arg2  <= cmd_data[12:8];
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_mode_valid) begin
                        r_status_data  <= '1;
                        r_status_wr_en <= 1'b1;
                        r_state        <= S_STATUS;
                    end else if (w_fire) begin
                        r_count <= w_pop_count;
                        if (w_pop_count == 5'd0) begin
                            r_core_start <= 1'b1;
                            r_state      <= S_RUN;
                        end else begin
                            r_data_rd_en <= 1'b1;
                            r_state      <= S_POP;
                        end
                    end
                end
                S_POP: begin
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_data_rd_en <= 1'b0;
                        r_core_start <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A done seen alongside the start pulse belongs to no instruction of ours.
                    if (r_core_start) begin
                        r_core_start <= 1'b0;
                    end else if (core_done) begin
                        r_status_data  <= word_size'({r_mode, 8'h00});
                        r_status_wr_en <= 1'b1;
                        r_state        <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    r_status_wr_en <= 1'b0;
                    r_state        <= S_SETUP;
                end
                default: r_state <= S_SETUP;
            endcase
        end
    end

    // The command FIFO is first-word fall-through, so the pop must land in the enable cycle.
    assign cmd_rd_en     = rst && (r_state == S_SETUP) && enable;
    assign data_rd_en    = r_data_rd_en;
    assign core_start    = r_core_start;
    assign status_wr_en  = r_status_wr_en;
    assign status_data   = r_status_data;
    assign mode          = r_mode;
    assign arg2          = r_arg2;
    assign busy          = (r_state != S_SETUP);
    assign next_mode_out = (r_state == S_SETUP) ? 2'b00 : 2'b01;

endmodule

// File: tb/tb_pea_sequencer.sv
// tb/tb_pea_sequencer.sv - randomized self-checking bench for pea_sequencer
module tb_pea_sequencer;

    localparam int FW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   cmd_data;
    logic          cmd_rd_en;
    logic          data_rd_en;
    logic [1:0]    next_mode_out;
    logic [7:0]    mode;
    logic [4:0]    arg2;
    logic [FW-1:0] result_free_space;
    logic [FW-1:0] status_free_space;
    logic          core_start;
    logic          core_done;
    logic          status_wr_en;
    logic [15:0]   status_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pea_sequencer #(.word_size(16), .buffer_size_out(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd_data(cmd_data),
        .cmd_rd_en(cmd_rd_en), .data_rd_en(data_rd_en), .next_mode_out(next_mode_out),
        .mode(mode), .arg2(arg2), .result_free_space(result_free_space),
        .status_free_space(status_free_space), .core_start(core_start),
        .core_done(core_done), .status_wr_en(status_wr_en), .status_data(status_data),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction semantics: how many operand words each mode consumes.
    function automatic int exp_pops(input logic [7:0] m, input logic [4:0] a);
        if (m == 8'd0 || m == 8'd2) return int'(a);
        if (m == 8'd1) return 1;
        return 0;
    endfunction

    task automatic drive_free_space();
`ifdef PEA_SEQ_FREE_SPACE_EN
        result_free_space = 5'd31;
        status_free_space = 5'd31;
`else
        result_free_space = 5'($urandom_range(0, 31));
        status_free_space = 5'($urandom_range(0, 31));
`endif
    endtask

    // One full instruction: idle cycles, enable, then track strobes until the status write.
    task automatic run_instr(input logic [15:0] cmd, input int idle, input int d, input bit coinc);
        logic [7:0]  m;
        logic [4:0]  a;
        logic [15:0] sdata;
        logic [7:0]  m_seen;
        logic [4:0]  a_seen;
        bit          valid;
        int n, t, cmds, pops, first_pop, last_pop, starts, start_t, status_t, overlap, idle_bad;
        int busy1, nmo1;
        m = cmd[7:0];
        a = cmd[12:8];
        valid = (m < 8'd4);
        n = exp_pops(m, a);
        cmds = 0; pops = 0; first_pop = -1; last_pop = -1; starts = 0; start_t = -1;
        status_t = -1; overlap = 0; idle_bad = 0; busy1 = 0; nmo1 = 0;
        sdata = '0; m_seen = '0; a_seen = '0;
        cmd_data = cmd;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            enable = 1'b0;
            core_done = 1'b0;
            drive_free_space();
            #1;
            if (cmd_rd_en || busy || next_mode_out != 2'b00) idle_bad++;
        end
        t = 0;
        while (status_t < 0 && t < 200) begin
            @(negedge clk);
            enable = 1'b1;
            core_done = 1'b0;
            drive_free_space();
            #1;
            if (int'(cmd_rd_en) + int'(data_rd_en) + int'(core_start) + int'(status_wr_en) > 1) overlap++;
            if (cmd_rd_en) cmds++;
            if (data_rd_en) begin
                pops++;
                if (first_pop < 0) first_pop = t;
                last_pop = t;
            end
            if (core_start) begin
                starts++;
                start_t = t;
            end
            if (status_wr_en) begin
                status_t = t;
                sdata = status_data;
                m_seen = mode;
                a_seen = arg2;
            end
            if (t == 1) begin
                busy1 = int'(busy);
                nmo1 = int'(next_mode_out);
            end
            if (core_start && coinc) core_done = 1'b1;
            if (start_t >= 0 && t == start_t + d) core_done = 1'b1;
            t++;
        end
        @(negedge clk);
        enable = 1'b0;
        core_done = 1'b0;
        #1;
        check("idle_quiet", idle_bad, 0);
        check("cmd_pops", cmds, 1);
        check("data_pops", pops, n);
        if (n > 0) begin
            check("first_pop_cycle", first_pop, 2);
            check("pops_consecutive", last_pop - first_pop + 1, n);
        end
        check("core_starts", starts, valid ? 1 : 0);
        if (valid) check("start_cycle", start_t, n + 2);
        check("status_cycle", status_t, valid ? n + 3 + d : 2);
        check("status_data", sdata, valid ? {m, 8'h00} : 16'hFFFF);
        check("mode_held", m_seen, m);
        check("arg2_held", a_seen, a);
        check("strobe_overlap", overlap, 0);
        check("busy_in_wait", busy1, 1);
        check("mode_out_in_wait", nmo1, 1);
        check("back_to_setup", next_mode_out, 2'b00);
        check("idle_after", busy, 0);
    endtask

    int pops_seen;
    int strobes_after;

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        cmd_data = 16'h0000;
        core_done = 1'b0;
        drive_free_space();
        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_rd_en", cmd_rd_en, 0);
        check("rst_data_rd_en", data_rd_en, 0);
        check("rst_core_start", core_start, 0);
        check("rst_status_wr_en", status_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_next_mode", next_mode_out, 2'b00);
        check("rst_mode", mode, 0);
        check("rst_arg2", arg2, 0);
        check("rst_status_data", status_data, 0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;

        run_instr(16'h0403, 0, 1, 1'b0);
        run_instr(16'h0400, 2, 1, 1'b0);
        run_instr(16'h0007, 1, 1, 1'b0);
        run_instr(16'h0002, 0, 2, 1'b1);
        run_instr(16'h1F01, 0, 3, 1'b0);
        run_instr(16'h1F00, 1, 1, 1'b1);

        // Reset in the middle of the operand pops.
        cmd_data = 16'h0500;
        pops_seen = 0;
        for (int i = 0; i < 30 && pops_seen < 2; i++) begin
            @(negedge clk);
            enable = 1'b1;
            #1;
            if (data_rd_en) pops_seen++;
        end
        check("rst_mid_pops_before", pops_seen, 2);
        rst = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_mid_data_rd_en", data_rd_en, 0);
        check("rst_mid_next_mode", next_mode_out, 2'b00);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mode", mode, 0);
        @(negedge clk);
        rst = 1'b1;
        strobes_after = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 5) core_done = 1'b1;
            else core_done = 1'b0;
            #1;
            strobes_after += int'(cmd_rd_en) + int'(data_rd_en) + int'(core_start) + int'(status_wr_en);
        end
        core_done = 1'b0;
        check("rst_mid_no_activity", strobes_after, 0);

`ifdef PEA_SEQ_FREE_SPACE_EN
        // Free-space gating: EVB needs room for arg2 results.
        cmd_data = 16'h0302;
        result_free_space = 5'd2;
        status_free_space = 5'd31;
        pops_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enable = 1'b1;
            #1;
            if (data_rd_en) pops_seen++;
        end
        check("fs_held_pops", pops_seen, 0);
        check("fs_held_busy", busy, 1);
        result_free_space = 5'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (data_rd_en) pops_seen++;
        end
        check("fs_fired_pops", pops_seen, 3);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`endif

        for (int k = 0; k < 40; k++) begin
            logic [15:0] c;
            c = 16'($urandom);
            if ($urandom_range(0, 4) != 0) c[7:0] = 8'($urandom_range(0, 3));
            run_instr(c, $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
